be8_memctl: RTL
===============

BE8_MEMCTL -- requirements
Module: be8_memctl

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra cycles inserted before every access completes; legal range 0..15.
REQ-002 Parameter IO_BASE, default 8'hE0: base of the 4-byte I/O window IO_BASE..IO_BASE+3.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_addr  input  8  CPU address.
REQ-006 cpu_rw  input  1  1 = write, 0 = read.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_rdata  output  8  read data returned to the CPU.
REQ-009 cpu_ready  output  1  access complete; the CPU advances only while high.
REQ-010 mem_addr  output  8  RAM address.
REQ-011 mem_we  output  1  RAM write strobe, one cycle.
REQ-012 mem_wdata  output  8  RAM write data.
REQ-013 mem_rdata  input  8  RAM read data, combinational from mem_addr.
REQ-014 out_data  output  8  output-port data.
REQ-015 out_valid  output  1  output-port byte pending.
REQ-016 out_ack  input  1  consumer takes the byte.
REQ-017 in_data  input  8  input-port data.
REQ-018 in_valid  input  1  input byte available.
REQ-019 in_ack  output  1  one-cycle pulse when the CPU consumes in_data.

Function
REQ-020 FSM states: WAIT (counting), DONE (cpu_ready=1 for exactly one cycle), STALL (I/O backpressure).
REQ-021 Latency: an unblocked access shall assert cpu_ready exactly WAIT_STATES+1 cycles after WAIT is entered; with WAIT_STATES=0, DONE follows after 1 cycle.
REQ-022 WAIT shall load a 4-bit counter with WAIT_STATES and decrement it to 0, then go to DONE or STALL.
REQ-023 A change of cpu_addr or cpu_rw while in WAIT shall reload the counter; the access restarts.
REQ-024 DONE shall always return to WAIT on the next cycle.
REQ-025 mem_addr shall equal cpu_addr at all times; mem_wdata shall equal cpu_wdata.
REQ-026 A RAM write (address outside the I/O window, cpu_rw=1) shall pulse mem_we in the DONE cycle only.
REQ-027 A RAM read shall drive cpu_rdata = mem_rdata in DONE.
REQ-028 IO_BASE+0 write: if out_valid=0, latch out_data=cpu_wdata and set out_valid in DONE; if out_valid=1, go to STALL until out_valid clears.
REQ-029 out_valid shall clear on the cycle after out_ack=1 is sampled while out_valid=1; out_ack while out_valid=0 is ignored.
REQ-030 IO_BASE+1 read: if in_valid=1, cpu_rdata=in_data and in_ack=1 in DONE; if in_valid=0, go to STALL until in_valid=1.
REQ-031 IO_BASE+2 read: cpu_rdata = {6'b0, in_valid, out_valid}; never stalls.
REQ-032 IO_BASE+3, writes to IO_BASE+1 and IO_BASE+2, and reads of IO_BASE+0: cpu_rdata=8'h00 on reads, writes discarded; no stall, no mem_we.
REQ-033 I/O-window accesses shall never assert mem_we.
REQ-034 When out_ack and a new port write resolve in the same cycle, the ack clears the old byte and the write is issued from STALL on the following cycle, giving DONE one cycle later; no byte is lost or duplicated.
REQ-035 cpu_rdata shall be 8'h00 outside DONE.

Reset
REQ-036 With rst=1 at a rising edge: state=WAIT, counter=WAIT_STATES, cpu_ready=0, cpu_rdata=8'h00, mem_we=0, out_data=8'h00, out_valid=0, in_ack=0.
REQ-037 Reset mid-access or mid-stall shall abort the access with no mem_we or in_ack pulse and drop any pending output byte.

Structure
REQ-038 A shared package shall hold the FSM state typedef, the I/O offsets (0..3) and the status bit positions.
REQ-039 The output-port holding register with its valid/ack logic shall be a sub-module named be8_outport.

Verification
REQ-040 WAIT_STATES=2, RAM read at 8'h10 containing 8'h5A: cpu_ready high on the 3rd cycle after reset release, cpu_rdata=8'h5A, mem_we=0.
REQ-041 RAM write 8'h33 to 8'h20: exactly one mem_we pulse coincident with cpu_ready; RAM[8'h20]=8'h33.
REQ-042 Write 8'hA1 to IO_BASE with out_ack held low, then write 8'hA2: second access stalls; out_ack pulse -> out_data=8'hA2 after ack; A1 and A2 each observed exactly once.
REQ-043 Read IO_BASE+1 with in_valid=0 for 5 cycles, then in_valid=1 with in_data=8'hC3: cpu_ready stays low until then; cpu_rdata=8'hC3; single in_ack.
REQ-044 Status read with out_valid=1 and in_valid=0 -> 8'h01; write to IO_BASE+3 -> no mem_we, no stall.
REQ-045 rst asserted during a stalled port write -> out_valid=0, cpu_ready=0, no in_ack or mem_we; normal timing resumes after release.

Source files
------------

// File: rtl/be8_memctl_pkg.sv
// Shared definitions for the be8 memory/I-O controller.
//   state_e        : controller FSM states
//   Io*            : offsets inside the 4-byte I/O window
//   Stat*Bit       : bit positions in the status byte (IO_BASE+2)
package be8_memctl_pkg;

  typedef enum logic [1:0] {
    StWait  = 2'd0,  // counting wait states
    StDone  = 2'd1,  // access completes, cpu_ready high for one cycle
    StStall = 2'd2   // I/O port not ready, holding the CPU
  } state_e;

  localparam logic [1:0] IoOut    = 2'd0;
  localparam logic [1:0] IoIn     = 2'd1;
  localparam logic [1:0] IoStatus = 2'd2;
  localparam logic [1:0] IoNone   = 2'd3;

  localparam int unsigned StatOutValidBit = 0;
  localparam int unsigned StatInValidBit  = 1;

endpackage

// File: rtl/be8_outport.sv
// Output-port holding register.
//   clk, rst   : clock, synchronous active-high reset (drops any pending byte)
//   load       : capture load_data and mark the byte pending
//   load_data  : byte to capture
//   ack        : consumer takes the pending byte
//   data       : held byte
//   valid      : byte pending
module be8_outport
  import be8_memctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    // ack only matters while a byte is actually pending
    if (valid_q && ack) begin
      valid_d = 1'b0;
    end
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/be8_memctl.sv
// be8 memory controller: wait-state generation, RAM strobe and a 4-byte I/O window
// (output port, input port, status, unused).
//   WAIT_STATES : extra cycles before each access completes (0..15)
//   IO_BASE     : base address of the I/O window
//   clk, rst    : clock, synchronous active-high reset
//   cpu_*       : CPU address/direction/data; cpu_ready marks completion
//   mem_*       : RAM address/strobe/data, mem_rdata combinational from mem_addr
//   out_*       : output-port byte, pending flag and consumer ack
//   in_*        : input-port byte, availability flag and consume pulse
module be8_memctl
  import be8_memctl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  IO_BASE     = 8'hE0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ready,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ack,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ack
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fresh_q, fresh_d;
  logic [7:0] addr_q;
  logic       rw_q;

  logic [7:0] io_rel;
  logic       in_io;
  logic [1:0] io_off;
  logic       out_wr, in_rd, stat_rd;
  logic       blocked, changed, done, out_load;
  logic [7:0] status;

  // Address decode
  assign io_rel  = cpu_addr - IO_BASE;
  assign in_io   = io_rel < 8'd4;
  assign io_off  = io_rel[1:0];
  assign out_wr  = in_io && (io_off == IoOut) && cpu_rw;
  assign in_rd   = in_io && (io_off == IoIn) && !cpu_rw;
  assign stat_rd = in_io && (io_off == IoStatus) && !cpu_rw;

  assign blocked = (out_wr && out_valid) || (in_rd && !in_valid);

  // The CPU moves to its next access just after seeing cpu_ready, so the first WAIT
  // cycle has no valid reference; only later cycles may detect a restart.
  assign changed = !fresh_q && ((cpu_addr != addr_q) || (cpu_rw != rw_q));
  assign done    = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    cnt_d   = WaitInit;
    unique case (state_q)
      StWait: begin
        if (!changed) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = blocked ? StStall : StDone;
          end
        end
      end
      StDone:  state_d = StWait;
      StStall: if (!blocked) state_d = StDone;
      default: state_d = StWait;
    endcase
    fresh_d = (state_d == StWait) && (state_q != StWait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWait;
      cnt_q   <= WaitInit;
      fresh_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
    end
  end

  // Reference copy of the request for restart detection; no reset needed.
  always_ff @(posedge clk) begin
    addr_q <= cpu_addr;
    rw_q   <= cpu_rw;
  end

  always_comb begin
    status                  = 8'h00;
    status[StatOutValidBit] = out_valid;
    status[StatInValidBit]  = in_valid;
  end

  always_comb begin
    cpu_ready = done;
    mem_we    = done && !in_io && cpu_rw;
    in_ack    = done && in_rd;
    out_load  = done && out_wr;
    cpu_rdata = 8'h00;
    if (done && !cpu_rw) begin
      if (!in_io) begin
        cpu_rdata = mem_rdata;
      end else if (in_rd) begin
        cpu_rdata = in_data;
      end else if (stat_rd) begin
        cpu_rdata = status;
      end
    end
  end

  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;

  be8_outport u_outport (
    .clk       (clk),
    .rst       (rst),
    .load      (out_load),
    .load_data (cpu_wdata),
    .ack       (out_ack),
    .data      (out_data),
    .valid     (out_valid)
  );

endmodule
